// File: rtl/keccak_padder_576.sv
// Message front end for the 576-bit-rate Keccak core: packs 64-bit words into rate
// blocks, inserts the domain byte and pad10*1, and double-buffers toward the permutation.
module keccak_padder_576 #(
   parameter logic [7:0] DOMAIN = 8'h06
) (
   input  logic         clk_i,
   input  logic         rst_b_i,
   input  logic [63:0]  in_i,
   input  logic         in_ready_i,
   input  logic         is_last_i,
   input  logic [2:0]   byte_num_i,
   output logic         buffer_full_o,
   output logic [575:0] out_o,
   output logic         out_ready_o,
   output logic         out_last_o,
   input  logic         f_ack_i
);

   localparam int unsigned WORD_W    = 64;
   localparam int unsigned RATE_W    = 576;
   localparam int unsigned NSLOT     = 9;
   localparam int unsigned CNT_W     = 4;
   localparam int unsigned LAST_SLOT = 8;

   logic [RATE_W-1:0] blk_q, blk_d;
   logic [CNT_W-1:0]  wcnt_q, wcnt_d;
   logic              full_q, full_d;
   logic              blk_last_q, blk_last_d;
   logic [RATE_W-1:0] out_q, out_d;
   logic              out_ready_q, out_ready_d;
   logic              out_last_q, out_last_d;

   logic [WORD_W-1:0] pad_word;
   logic              accept;
   logic              xfer;

   assign accept = in_ready_i & ~full_q;
   assign xfer   = full_q & (~out_ready_q | f_ack_i);

   // Final word: valid message bytes, then the domain byte, then zeros.
   always_comb begin
      pad_word = '0;
      for (int unsigned b = 0; b < 8; b++) begin
         if (b < 32'(byte_num_i)) begin
            pad_word[WORD_W-1-8*b -: 8] = in_i[WORD_W-1-8*b -: 8];
         end else if (b == 32'(byte_num_i)) begin
            pad_word[WORD_W-1-8*b -: 8] = DOMAIN;
         end
      end
   end

   always_comb begin
      blk_d       = blk_q;
      wcnt_d      = wcnt_q;
      full_d      = full_q;
      blk_last_d  = blk_last_q;
      out_d       = out_q;
      out_ready_d = out_ready_q;
      out_last_d  = out_last_q;

      // Hand the assembled block to the output register, or retire an acked one.
      if (xfer) begin
         out_d       = blk_q;
         out_ready_d = 1'b1;
         out_last_d  = blk_last_q;
         full_d      = 1'b0;
         blk_last_d  = 1'b0;
         blk_d       = '0;
      end else if (f_ack_i && out_ready_q) begin
         out_ready_d = 1'b0;
         out_last_d  = 1'b0;
      end

      // accept and xfer are exclusive: both depend on full_q with opposite polarity.
      if (accept) begin
         for (int unsigned k = 0; k < NSLOT; k++) begin
            if (CNT_W'(k) == wcnt_q) begin
               blk_d[RATE_W-1-WORD_W*k -: WORD_W] = is_last_i ? pad_word : in_i;
            end else if (is_last_i && (CNT_W'(k) > wcnt_q)) begin
               blk_d[RATE_W-1-WORD_W*k -: WORD_W] = '0;
            end
         end
         if (is_last_i) begin
            blk_d[7:0] = blk_d[7:0] | 8'h80;
            full_d     = 1'b1;
            blk_last_d = 1'b1;
            wcnt_d     = '0;
         end else if (wcnt_q == CNT_W'(LAST_SLOT)) begin
            full_d = 1'b1;
            wcnt_d = '0;
         end else begin
            wcnt_d = wcnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_b_i) begin
         blk_q       <= '0;
         wcnt_q      <= '0;
         full_q      <= 1'b0;
         blk_last_q  <= 1'b0;
         out_q       <= '0;
         out_ready_q <= 1'b0;
         out_last_q  <= 1'b0;
      end else begin
         blk_q       <= blk_d;
         wcnt_q      <= wcnt_d;
         full_q      <= full_d;
         blk_last_q  <= blk_last_d;
         out_q       <= out_d;
         out_ready_q <= out_ready_d;
         out_last_q  <= out_last_d;
      end
   end

   assign buffer_full_o = full_q;
   assign out_o         = out_q;
   assign out_ready_o   = out_ready_q;
   assign out_last_o    = out_last_q;

endmodule

// File: tb/tb_keccak_padder_576.sv
// Bench for keccak_padder_576: directed and random messages checked against a
// byte-level SHA3 padding model; a monitor compares every block delivered.
module tb_keccak_padder_576;

   localparam logic [7:0] DOMAIN = 8'h06;

   logic         clk = 1'b0;
   logic         rst_b = 1'b0;
   logic [63:0]  in_w = '0;
   logic         in_ready = 1'b0;
   logic         is_last = 1'b0;
   logic [2:0]   byte_num = '0;
   logic         buffer_full;
   logic [575:0] out_blk;
   logic         out_ready;
   logic         out_last;
   logic         auto_ack = 1'b0;
   logic         ack_force = 1'b0;
   logic         ack_rand = 1'b0;
   logic         f_ack;

   int n_chk  = 0;
   int n_pass = 0;

   logic [7:0]   mb[$];
   logic [575:0] exp_q[$];
   logic         exp_last_q[$];

   logic         mon_en = 1'b0;
   logic         seen = 1'b0;
   logic         acked = 1'b0;
   logic [575:0] cur_blk = '0;
   logic         cur_last = 1'b0;

   assign f_ack = auto_ack ? ack_rand : ack_force;

   keccak_padder_576 #(.DOMAIN(DOMAIN)) dut (
      .clk_i        (clk),
      .rst_b_i      (rst_b),
      .in_i         (in_w),
      .in_ready_i   (in_ready),
      .is_last_i    (is_last),
      .byte_num_i   (byte_num),
      .buffer_full_o(buffer_full),
      .out_o        (out_blk),
      .out_ready_o  (out_ready),
      .out_last_o   (out_last),
      .f_ack_i      (f_ack)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [575:0] obs, input logic [575:0] expv);
      n_chk++;
      assert (obs === expv) n_pass++;
      else $error("FAIL %s: got %h expected %h", tag, obs, expv);
   endtask

   always @(posedge clk) acked <= out_ready & f_ack;

   // Block monitor: each newly presented block is popped from the model queue;
   // a block still waiting for its ack must not change.
   always @(posedge clk) begin
      #2;
      ack_rand = ($urandom_range(0, 2) == 0);
      if (mon_en) begin
         if (out_ready !== 1'b1) begin
            seen = 1'b0;
         end else if (!seen || acked) begin
            chk("blk_avail", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
               cur_blk  = exp_q.pop_front();
               cur_last = exp_last_q.pop_front();
               chk("blk_data", out_blk, cur_blk);
               chk("blk_last", out_last, cur_last);
            end
            seen = 1'b1;
         end else begin
            chk("blk_stable", out_blk, cur_blk);
         end
      end
   end

   task automatic put_word(input logic [63:0] w, input logic last, input logic [2:0] bn);
      int n = 0;
      in_w     = w;
      in_ready = 1'b1;
      is_last  = last;
      byte_num = bn;
      while (buffer_full && n < 1000) begin
         @(negedge clk);
         n++;
      end
      chk("accept_timeout", n < 1000, 1);
      @(negedge clk);
   endtask

   // Model: message ++ DOMAIN ++ zeros up to a 72-byte multiple, final byte |= 0x80.
   task automatic send_msg();
      logic [7:0]   p[$];
      logic [575:0] b;
      logic [63:0]  w;
      int           len;
      int           nblk;
      len = mb.size();
      p = mb;
      p.push_back(DOMAIN);
      while (p.size() % 72 != 0) p.push_back(8'h00);
      p[p.size()-1] = p[p.size()-1] | 8'h80;
      nblk = p.size() / 72;
      for (int i = 0; i < nblk; i++) begin
         for (int j = 0; j < 72; j++) b[575-8*j -: 8] = p[72*i+j];
         exp_q.push_back(b);
         exp_last_q.push_back(i == nblk - 1);
      end
      for (int i = 0; i < len / 8; i++) begin
         for (int j = 0; j < 8; j++) w[63-8*j -: 8] = mb[8*i+j];
         put_word(w, 1'b0, 3'd0);
      end
      w = {$urandom, $urandom};
      for (int j = 0; j < len % 8; j++) w[63-8*j -: 8] = mb[8*(len/8)+j];
      put_word(w, 1'b1, 3'(len % 8));
      in_ready = 1'b0;
      is_last  = 1'b0;
   endtask

   task automatic wait_ready();
      int n = 0;
      while (out_ready !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("ready_timeout", out_ready, 1);
   endtask

   task automatic wait_drain();
      int n = 0;
      while ((exp_q.size() != 0 || out_ready !== 1'b0) && n < 3000) begin
         @(negedge clk);
         n++;
      end
      chk("drain_left", exp_q.size(), 0);
   endtask

   task automatic rand_bytes(input int n);
      for (int i = 0; i < n; i++) mb.push_back(8'($urandom));
   endtask

   initial begin
      logic [63:0] w;

      // Reset with random inputs
      repeat (2) begin
         @(negedge clk);
         in_w      = {$urandom, $urandom};
         in_ready  = 1'($urandom);
         is_last   = 1'($urandom);
         byte_num  = 3'($urandom);
         ack_force = 1'($urandom);
      end
      chk("rst_out", out_blk, 0);
      chk("rst_ready", out_ready, 0);
      chk("rst_last", out_last, 0);
      chk("rst_full", buffer_full, 0);
      in_ready  = 1'b0;
      ack_force = 1'b0;
      rst_b     = 1'b1;
      mon_en    = 1'b1;
      @(negedge clk);

      // Empty message: latency and exact block
      mb.delete();
      send_msg();
      chk("empty_ready_e", out_ready, 0);
      chk("empty_full_e", buffer_full, 1);
      @(negedge clk);
      chk("empty_ready_e1", out_ready, 1);
      chk("empty_w0", out_blk[575:512], 64'h0600000000000000);
      chk("empty_mid", out_blk[511:8], 0);
      chk("empty_tail", out_blk[7:0], 8'h80);
      chk("empty_last", out_last, 1);
      ack_force = 1'b1;
      @(negedge clk);
      ack_force = 1'b0;
      chk("empty_ack_clr", out_ready, 0);
      chk("empty_ack_last", out_last, 0);

      // 72-byte message: one verbatim block plus a pad-only block
      mb.delete();
      for (int k = 0; k < 9; k++) begin
         w = 64'h0001020304050607 + 64'(k);
         for (int j = 0; j < 8; j++) mb.push_back(w[63-8*j -: 8]);
      end
      auto_ack = 1'b1;
      send_msg();
      wait_drain();

      // 71 bytes: domain and final pad bit share the last byte
      auto_ack = 1'b0;
      mb.delete();
      rand_bytes(64);
      w = 64'hAABBCCDDEEFF1122;
      for (int j = 0; j < 7; j++) mb.push_back(w[63-8*j -: 8]);
      send_msg();
      wait_ready();
      chk("bound_w8", out_blk[63:0], 64'hAABBCCDDEEFF1186);
      chk("bound_last", out_last, 1);
      auto_ack = 1'b1;
      wait_drain();

      // Back-pressure: ack withheld 30 cycles, then released with the next block waiting
      auto_ack  = 1'b0;
      ack_force = 1'b0;
      mb.delete();
      rand_bytes(18 * 8 + $urandom_range(0, 7));
      fork
         send_msg();
         begin
            repeat (30) @(negedge clk);
            chk("bp_full", buffer_full, 1);
            chk("bp_ready", out_ready, 1);
            chk("bp_last", out_last, 0);
            ack_force = 1'b1;
            @(negedge clk);
            ack_force = 1'b0;
            chk("bp_nogap", out_ready, 1);
            chk("bp_free", buffer_full, 0);
            auto_ack = 1'b1;
         end
      join
      wait_drain();

      // Reset in the middle of a handshake and a partial block
      auto_ack = 1'b0;
      mb.delete();
      rand_bytes(10);
      send_msg();
      wait_ready();
      for (int i = 0; i < 4; i++) put_word({$urandom, $urandom}, 1'b0, 3'd0);
      in_ready = 1'b0;
      chk("rm_ready_pre", out_ready, 1);
      rst_b = 1'b0;
      @(negedge clk);
      chk("rm_out", out_blk, 0);
      chk("rm_ready", out_ready, 0);
      chk("rm_last", out_last, 0);
      chk("rm_full", buffer_full, 0);
      rst_b = 1'b1;
      exp_q.delete();
      exp_last_q.delete();
      mb.delete();
      mb.push_back(8'h11);
      mb.push_back(8'h22);
      mb.push_back(8'h33);
      send_msg();
      wait_ready();
      chk("rm_w0", out_blk[575:512], 64'h1122330600000000);
      chk("rm_w1_8", out_blk[511:0], 512'h80);
      auto_ack = 1'b1;
      wait_drain();

      // Random messages with random gaps and random acks
      repeat (25) begin
         mb.delete();
         rand_bytes($urandom_range(0, 200));
         send_msg();
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      wait_drain();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/keccak_padder_576.md
# keccak_padder_576

Message-side front end for the 576-bit-rate Keccak core (SHA3-512 rate). It accepts the message as 64-bit words and assembles them into 576-bit rate blocks. It applies the domain-separation byte and pad10*1 padding, then presents each block to the permutation's `in`/`in_ready`/`ack` absorb port. It is the producer at that interface. It double-buffers one block so the next block can be collected while the permutation is busy.

## Interface
- `DOMAIN`, 8'h06, domain/padding-start byte inserted after the last message byte (8'h1F for SHAKE).
- `clk`  in  1  clock; all state updates on rising edge.
- `rst_b`  in  1  synchronous reset, active low.
- `in`  in  64  message word; byte 0 = `in[63:56]`, byte 7 = `in[7:0]`.
- `in_ready`  in  1  `in` valid this cycle.
- `is_last`  in  1  with `in_ready`: this is the final word of the message.
- `byte_num`  in  3  with `is_last`: number of valid bytes in `in` (0..7); ignored otherwise.
- `buffer_full`  out  1  1 = word not accepted this cycle; source must hold.
- `out`  out  576  rate block to the permutation; word k occupies `out[575-64k -: 64]`.
- `out_ready`  out  1  `out` holds a valid block.
- `out_last`  out  1  with `out_ready`: block is the final block of the message.
- `f_ack`  in  1  permutation has taken `out`.

## Operation
- Two registers: assembly buffer `blk` with word counter `wcnt` (0..8) and flag `full`; output register `out`/`out_ready`/`out_last`.
- A word is accepted when `in_ready & ~buffer_full`. `buffer_full = full`, combinational from registers, never from `in_ready`.
- Normal word (`is_last=0`): written to slot `wcnt`, `wcnt++`. When `wcnt` was 8, set `full=1` and `wcnt` to 0.
- Last word (`is_last=1`), at slot s:
  - Bytes 0..`byte_num`-1 are taken from `in`.
  - Byte `byte_num` = `DOMAIN`.
  - Remaining bytes of the slot and all slots s+1..8 are zero.
  - `blk[7:0] |= 8'h80`.
  - Set `full=1` and `blk_last=1`, and reset `wcnt` to 0.
  - The last word always occupies a slot. A message ending on a word boundary sends `is_last` with `byte_num=0` (its `in` is ignored). This slot may be word 0 of a fresh block, so no overflow case exists.
  - When `byte_num=7` in slot 8, byte 7 becomes `DOMAIN|8'h80`.
- Transfer: when `full & (~out_ready | f_ack)`, the next edge performs:
  - `out <= blk`, `out_ready <= 1`, `out_last <= blk_last`.
  - `full <= 0`, `blk_last <= 0`, `blk <= 0`.
- `f_ack` while `out_ready=1` with no transfer clears `out_ready` and `out_last`; `out` keeps its value.
- `f_ack` while `out_ready=0` is ignored.
- `out` is stable whenever `out_ready=1` until the edge sampling `f_ack=1`.
- After a last block transfers, the block accepts the next message immediately; there is no idle state.
- Unused slots of a non-final block never exist; a partially filled `blk` waits indefinitely for words.

## Timing
- Reset values:
  - `out=0`, `out_ready=0`, `out_last=0`, `buffer_full=0`.
  - `wcnt=0`, `blk=0`, `full=0`, `blk_last=0`.
- Reset is applied mid-block or mid-handshake with no residue: a pending block is discarded and `out_ready` drops.
- Latency: block-completing word sampled at edge E; `full=1` after E; `out_ready=1` after E+1 if the output register is free.
- `buffer_full` is high for at least the one cycle after E. It stays high while the output register is occupied and unacked.
- Simultaneous `f_ack` and `full`: new block loads, `out_ready` stays 1 with no gap.
- Throughput: one word per cycle except the one stall cycle per block.
- `f_ack` may arrive any cycle after `out_ready` rises, before the permutation finishes. Padder correctness does not depend on its timing.

## Test plan
- Reset: assert `rst_b=0` two cycles with random inputs → all outputs 0, `buffer_full=0`.
- Empty message: single `is_last=1`, `byte_num=0`. Required response:
  - Word 0 = 64'h0600000000000000, words 1..8 = 0 except `out[7:0]=8'h80`.
  - `out_last=1`, `out_ready` two edges after acceptance.
- 72-byte message: words k=0..8 = 64'h0001020304050607 + k, then `is_last`, `byte_num=0`. Required response:
  - Block 1 is the 9 words verbatim, `out_last=0`.
  - After `f_ack`, block 2 = word0 64'h0600000000000000, `out[7:0]=8'h80`, `out_last=1`.
- Boundary pad byte: 8 full words, then `is_last`, `byte_num=7`, `in`=64'hAABBCCDDEEFF1122 → word 8 = 64'hAABBCCDDEEFF1186.
- Back-pressure: hold `f_ack=0` for 30 cycles while driving 18 words continuously. Required response:
  - Block 1 stays stable on `out`.
  - `buffer_full` rises once block 2 is assembled; no word is lost or duplicated.
  - After `f_ack`, block 2 appears on the same edge `f_ack` is sampled. Check this edge with `f_ack` and `full` coincident.
- Reset mid-operation: after 4 words and with `out_ready=1`, pulse `rst_b` low → outputs cleared. A following 1-word message (`byte_num=3`, 64'h11223344_00000000) gives word 0 = 64'h1122330600000000.
